// File: rtl/int_issue_block_pkg.sv
// int_issue_block_pkg: opcode, width and state definitions shared by the integer issue block and its ALU
package int_issue_block_pkg;
  localparam logic [1:0] OP_IMM = 2'b01;
  localparam logic [1:0] OP_REG = 2'b10;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;
endpackage

// File: rtl/int_issue_block_alu.sv
// int_alu: combinational rs1+imm / rs1+rs2 adder selected by opcode, carry dropped
import int_issue_block_pkg::*;
module int_alu #(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic [1:0]            opcode,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] result
);
  assign result = rs1 + (opcode == OP_REG ? rs2 : imm);
endmodule

// File: rtl/int_issue_block.sv
// int_issue_block: issue-queue consumer that executes one op, then holds its tagged result on the CDB until granted (INT_ISSUE_BACK_TO_BACK_EN allows accept on the grant cycle)
import int_issue_block_pkg::*;
module int_issue_block #(
  parameter int EXEC_LATENCY = 1,
  parameter int TAG_WIDTH    = TAG_W,
  parameter int DATA_WIDTH   = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issueque_ready,
  input  logic [1:0]            issueque_opcode,
  input  logic [DATA_WIDTH-1:0] issueque_rs1_data,
  input  logic [DATA_WIDTH-1:0] issueque_rs2_data,
  input  logic [DATA_WIDTH-1:0] issueque_imm_data,
  input  logic [TAG_WIDTH-1:0]  issueque_rd_tag,
  output logic [1:0]            read_pointer,
  output logic                  issueblk_done,
  output logic                  cdb_req,
  input  logic                  cdb_grant,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data
);
  localparam logic [3:0] LAT_M1 = 4'(EXEC_LATENCY - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] result;
  logic accept_slot;
  int_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode (issueque_opcode),
    .rs1    (issueque_rs1_data),
    .rs2    (issueque_rs2_data),
    .imm    (issueque_imm_data),
    .result (result)
  );
`ifdef INT_ISSUE_BACK_TO_BACK_EN
  assign accept_slot = state == IDLE || (state == WAIT_CDB && cdb_grant);
`else
  assign accept_slot = state == IDLE;
`endif
  assign issueblk_done = accept_slot && issueque_ready && !reset && !flush;
  assign cdb_req = state == WAIT_CDB;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (issueblk_done) begin
      state_n = EXEC_LATENCY == 1 ? WAIT_CDB : EXEC;
      cnt_n = LAT_M1;
    end else if (state == EXEC) begin
      state_n = cnt == 4'd1 ? WAIT_CDB : EXEC;
      cnt_n = cnt - 4'd1;
    end else if (state == WAIT_CDB && cdb_grant) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= IDLE;
      cnt <= '0;
      read_pointer <= '0;
      cdb_tag <= '0;
      cdb_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (issueblk_done) begin
        read_pointer <= read_pointer + 2'd1;
        cdb_tag <= issueque_rd_tag;
        cdb_data <= result;
      end
    end
  end
endmodule

// File: doc/int_issue_block.md
Name: int_issue_block

Overview:
- Consumer end of the integer issue queue's issue interface.
- Drives the queue's read_pointer and accepts ready entries with a one-cycle issueblk_done strobe.
- Executes the 2-bit opcode over EXEC_LATENCY cycles, then holds the tagged result and requests the common data bus (CDB) from the arbiter until granted.
- Sits between the issue queue and the CDB arbiter; one instance per integer queue.

Parameters:
- EXEC_LATENCY, 1, execute cycles from the accept edge to the first cdb_req cycle; legal range 1..15.
- TAG_WIDTH, 6, width of the rd tag (physical/ROB tag).
- DATA_WIDTH, 32, operand and result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (mispredict); same effect as reset on this block.
- issueque_ready  in  1  entry at read_pointer is valid with all needed operands.
- issueque_opcode  in  2  01 = rs1+imm, 10 = rs1+rs2; 00/11 never ready.
- issueque_rs1_data  in  DATA_WIDTH  operand 1.
- issueque_rs2_data  in  DATA_WIDTH  operand 2.
- issueque_imm_data  in  DATA_WIDTH  immediate.
- issueque_rd_tag  in  TAG_WIDTH  destination tag.
- read_pointer  out  2  queue slot presented for issue.
- issueblk_done  out  1  accept strobe, combinational; queue clears the slot at this edge.
- cdb_req  out  1  result pending broadcast.
- cdb_grant  in  1  arbiter grant; transfer completes at the edge where cdb_req & cdb_grant.
- cdb_tag  out  TAG_WIDTH  result tag, stable while cdb_req.
- cdb_data  out  DATA_WIDTH  result data, stable while cdb_req.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset/flush state:
  - state = IDLE, read_pointer = 0, exec counter = 0.
  - cdb_req = 0, cdb_tag = 0, cdb_data = 0.
  - issueblk_done = 0 during any cycle in which reset or flush is high.
- States:
  - IDLE: awaiting an issue.
  - EXEC: counting execute cycles.
  - WAIT_CDB: cdb_req = 1, awaiting grant.
- Accept condition: issueblk_done = (state == IDLE) & issueque_ready & ~reset & ~flush. This is the cycle-0 accept.
- On accept edge:
  - Latch rd_tag and the result: opcode 01 gives rs1 + imm; opcode 10 gives rs1 + rs2. Arithmetic is modulo 2^DATA_WIDTH, carry dropped.
  - read_pointer increments by 1 and wraps 3 -> 0.
  - If EXEC_LATENCY = 1, go to WAIT_CDB; else go to EXEC with counter = EXEC_LATENCY - 1.
- EXEC: counter decrements each cycle; on the edge where counter = 1, go to WAIT_CDB.
- Latency: cdb_req is first high in cycle EXEC_LATENCY after the accept cycle.
- WAIT_CDB:
  - cdb_req = 1; cdb_tag and cdb_data hold their values.
  - On the edge where cdb_grant = 1: cdb_req drops and state goes to IDLE.
  - Without the optional feature, the next accept occurs no earlier than the cycle after the grant.
- cdb_grant while cdb_req = 0 is ignored.
- Flush has priority over grant and accept. A pending result is discarded and never broadcast; read_pointer returns to 0, matching the queue's flush-to-slot-0.
- issueque_ready is don't-care outside IDLE; read_pointer is stable outside accept edges.

Optional Feature:
- Macro: INT_ISSUE_BACK_TO_BACK_EN.
- With the macro defined:
  - In WAIT_CDB with cdb_grant = 1 and issueque_ready = 1, issueblk_done asserts in the same cycle.
  - At that edge the old result leaves, the new result and tag load, and read_pointer advances.
  - Next state is EXEC, or WAIT_CDB if EXEC_LATENCY = 1 (cdb_req stays high).
  - Sustained throughput: 1 instruction/cycle at latency 1.
- Without the macro: accept occurs only in IDLE, giving at most 1 instruction per 2 cycles.

Decomposition:
- Shared package contents:
  - Opcode constants OP_IMM = 2'b01 and OP_REG = 2'b10.
  - Tag/data width constants.
  - State enum {IDLE, EXEC, WAIT_CDB}.
- One natural sub-module: int_alu, a combinational opcode/operand to result unit. It is reused by later execution blocks.

Test Plan:
- Reset, then EXEC_LATENCY = 1: ready = 1, opcode = 01, rs1 = 5, imm = 7, tag = 0x12 → done pulses in cycle 0 and read_pointer 0 → 1. Cycle 1: cdb_req = 1, cdb_tag = 0x12, cdb_data = 12.
- Opcode 10, rs1 = 0xFFFFFFFF, rs2 = 2, EXEC_LATENCY = 3 → cdb_req first high in cycle 3 with data 1. Hold grant low for 4 cycles → tag and data stay stable; grant → req drops the next cycle.
- Four accepts with immediate grants → read_pointer sequence 0, 1, 2, 3, 0 (wrap).
- Flush asserted in WAIT_CDB at the same cycle as grant → req = 0 the next cycle, read_pointer = 0, no further done until ready returns.
- Ready held high while in WAIT_CDB (macro off) → done stays 0 until IDLE. Macro on, with grant and ready in the same cycle → done = 1, new result on the CDB the next cycle with no req gap.
- Opcode 00 or 11 with ready = 0 → no done, read_pointer unchanged.
